// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the MIPS-subset datapath. It has configurable memory wait
// states, optional exception handling and a $29 init step after reset.
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 3,
  parameter bit          EXC_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP_Code,
  input  logic [5:0] Funct,
  input  logic       Z,
  input  logic       Overflow,
  output logic [2:0] PC_Src,
  output logic [1:0] IorD,
  output logic [1:0] Reg_Dst,
  output logic [1:0] MemToReg,
  output logic       ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [2:0] ALU_Op,
  output logic       PC_Write,
  output logic       Mem_WR,
  output logic       IR_Write,
  output logic       MDR_Write,
  output logic       Reg_Write,
  output logic       A_Write,
  output logic       B_Write,
  output logic       ALUOut_Write,
  output logic       EPC_Write
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MEM_WAIT);

  typedef enum logic [4:0] {
    StReset, StFetch, StDecode, StRExec, StRWb, StAddiExec, StAddiWb, StMemAddr,
    StLwRead, StLwWb, StSwWrite, StBranch, StJump, StJr, StExcEpc, StExcRead, StExcJump
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cause_q, cause_d;

  logic funct_addsub, funct_alu, multi_cycle, cnt_last;

  assign funct_addsub = (Funct == FnAdd) || (Funct == FnSub);
  assign funct_alu    = funct_addsub || (Funct == FnAnd);
  assign multi_cycle  = (state_q == StFetch) || (state_q == StLwRead) ||
                        (state_q == StSwWrite) || (state_q == StExcRead);
  assign cnt_last     = (cnt_q == LastCnt);

  // State, wait counter and exception cause registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReset;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state, counter and cause logic.
  always_comb begin
    logic bad_op;
    state_d = state_q;
    cause_d = cause_q;
    bad_op  = 1'b0;
    // Counter is zero whenever a multi-cycle state is entered, since every exit clears it.
    cnt_d   = (multi_cycle && !cnt_last) ? cnt_q + 1'b1 : '0;

    unique case (state_q)
      StReset:    state_d = StFetch;
      StFetch:    if (cnt_last) state_d = StDecode;
      StDecode: begin
        case (OP_Code)
          OpRType: begin
            if (funct_alu)           state_d = StRExec;
            else if (Funct == FnJr)  state_d = StJr;
            else                     bad_op  = 1'b1;
          end
          OpAddi:       state_d = StAddiExec;
          OpLw, OpSw:   state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          default:      bad_op  = 1'b1;
        endcase
        if (bad_op) begin
          if (EXC_EN) begin
            state_d = StExcEpc;
            cause_d = 1'b0;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StRExec: begin
        if (EXC_EN && Overflow && funct_addsub) begin
          state_d = StExcEpc;
          cause_d = 1'b1;
        end else begin
          state_d = StRWb;
        end
      end
      StAddiExec: begin
        if (EXC_EN && Overflow) begin
          state_d = StExcEpc;
          cause_d = 1'b1;
        end else begin
          state_d = StAddiWb;
        end
      end
      StMemAddr:  state_d = (OP_Code == OpSw) ? StSwWrite : StLwRead;
      StLwRead:   if (cnt_last) state_d = StLwWb;
      StSwWrite:  if (cnt_last) state_d = StFetch;
      StExcEpc:   state_d = StExcRead;
      StExcRead:  if (cnt_last) state_d = StExcJump;
      StRWb, StAddiWb, StLwWb, StBranch, StJump, StJr, StExcJump: state_d = StFetch;
      default:    state_d = StReset;
    endcase
  end

  // Datapath control decode; BRANCH PC_Write follows Z combinationally.
  always_comb begin
    PC_Src       = 3'd0;
    IorD         = 2'd0;
    Reg_Dst      = 2'd0;
    MemToReg     = 2'd0;
    ALU_SrcA     = 1'b0;
    ALU_SrcB     = 2'd0;
    ALU_Op       = 3'b000;
    PC_Write     = 1'b0;
    Mem_WR       = 1'b0;
    IR_Write     = 1'b0;
    MDR_Write    = 1'b0;
    Reg_Write    = 1'b0;
    A_Write      = 1'b0;
    B_Write      = 1'b0;
    ALUOut_Write = 1'b0;
    EPC_Write    = 1'b0;

    unique case (state_q)
      StReset: begin
        // Init $29 <= 227 only once reset has been released.
        if (!reset) begin
          Reg_Write = 1'b1;
          Reg_Dst   = 2'd2;
          MemToReg  = 2'd2;
        end
      end
      StFetch: begin
        ALU_SrcB = 2'd1;
        ALU_Op   = 3'b001;
        if (cnt_last) begin
          PC_Write = 1'b1;
          IR_Write = 1'b1;
        end
      end
      StDecode: begin
        A_Write      = 1'b1;
        B_Write      = 1'b1;
        ALUOut_Write = 1'b1;
        ALU_SrcB     = 2'd3;
        ALU_Op       = 3'b001;
      end
      StRExec: begin
        ALU_SrcA     = 1'b1;
        ALUOut_Write = 1'b1;
        case (Funct)
          FnSub:   ALU_Op = 3'b010;
          FnAnd:   ALU_Op = 3'b011;
          default: ALU_Op = 3'b001;
        endcase
      end
      StRWb: begin
        Reg_Write = 1'b1;
        Reg_Dst   = 2'd1;
      end
      StAddiExec, StMemAddr: begin
        ALU_SrcA     = 1'b1;
        ALU_SrcB     = 2'd2;
        ALU_Op       = 3'b001;
        ALUOut_Write = 1'b1;
      end
      StAddiWb:   Reg_Write = 1'b1;
      StLwRead: begin
        IorD      = 2'd1;
        MDR_Write = cnt_last;
      end
      StLwWb: begin
        Reg_Write = 1'b1;
        MemToReg  = 2'd1;
      end
      StSwWrite: begin
        IorD   = 2'd1;
        Mem_WR = 1'b1;
      end
      StBranch: begin
        ALU_SrcA = 1'b1;
        ALU_Op   = 3'b010;
        PC_Src   = 3'd1;
        PC_Write = (OP_Code == OpBeq) ? Z : !Z;
      end
      StJump: begin
        PC_Write = 1'b1;
        PC_Src   = 3'd2;
      end
      StJr: begin
        PC_Write = 1'b1;
        PC_Src   = 3'd4;
      end
      StExcEpc: begin
        ALU_SrcB  = 2'd1;
        ALU_Op    = 3'b010;
        EPC_Write = 1'b1;
      end
      StExcRead: begin
        IorD      = cause_q ? 2'd3 : 2'd2;
        MDR_Write = cnt_last;
      end
      StExcJump: begin
        PC_Write = 1'b1;
        PC_Src   = 3'd3;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: three parameter sets, each checked cycle by cycle
// against an instruction-timeline reference model.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [2:0] pc_src;
    logic [1:0] iord;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       epc_write;
  } ctl_t;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [5:0] op = '0;
  logic [5:0] fn = '0;
  logic       z = 1'b0;
  logic       ov = 1'b0;
  int         sel = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  ctl_t       got [3];
  ctl_t       exp_q [$];

  // Per-instance parameters: {MEM_WAIT, EXC_EN}
  int   cfg_w   [3] = '{1, 2, 0};
  bit   cfg_exc [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 2 : 0;
    localparam bit          E = (g == 1) ? 1'b0 : 1'b1;
    mc_control_fsm #(.MEM_WAIT(W), .CNT_W(3), .EXC_EN(E)) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .OP_Code      (op),
      .Funct        (fn),
      .Z            (z),
      .Overflow     (ov),
      .PC_Src       (got[g].pc_src),
      .IorD         (got[g].iord),
      .Reg_Dst      (got[g].reg_dst),
      .MemToReg     (got[g].mem_to_reg),
      .ALU_SrcA     (got[g].alu_src_a),
      .ALU_SrcB     (got[g].alu_src_b),
      .ALU_Op       (got[g].alu_op),
      .PC_Write     (got[g].pc_write),
      .Mem_WR       (got[g].mem_wr),
      .IR_Write     (got[g].ir_write),
      .MDR_Write    (got[g].mdr_write),
      .Reg_Write    (got[g].reg_write),
      .A_Write      (got[g].a_write),
      .B_Write      (got[g].b_write),
      .ALUOut_Write (got[g].aluout_write),
      .EPC_Write    (got[g].epc_write)
    );
  end

  task automatic check_eq(input string tag, input ctl_t act, input ctl_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d): got %h expected %h", tag, sel, act, exp);
    end
  endtask

  // Exception timeline: EPC save, vector read, vector jump.
  task automatic push_exc(input int w, input bit cause);
    ctl_t c;
    c = '0; c.alu_src_b = 2'd1; c.alu_op = 3'b010; c.epc_write = 1'b1;
    exp_q.push_back(c);
    for (int i = 0; i <= w; i++) begin
      c = '0; c.iord = cause ? 2'd3 : 2'd2; c.mdr_write = (i == w);
      exp_q.push_back(c);
    end
    c = '0; c.pc_write = 1'b1; c.pc_src = 3'd3;
    exp_q.push_back(c);
  endtask

  // Expected control word for every cycle of one instruction, FETCH to last cycle.
  task automatic build_expect(input int w, input bit exc, input logic [5:0] o,
                              input logic [5:0] f, input logic zz, input logic oo);
    ctl_t c;
    bit   r_alu, addsub;
    exp_q.delete();
    for (int i = 0; i <= w; i++) begin
      c = '0; c.alu_src_b = 2'd1; c.alu_op = 3'b001;
      if (i == w) begin c.pc_write = 1'b1; c.ir_write = 1'b1; end
      exp_q.push_back(c);
    end
    c = '0; c.a_write = 1'b1; c.b_write = 1'b1; c.aluout_write = 1'b1;
    c.alu_src_b = 2'd3; c.alu_op = 3'b001;
    exp_q.push_back(c);
    addsub = (f == 6'h20) || (f == 6'h22);
    r_alu  = addsub || (f == 6'h24);
    if (o == 6'h00 && r_alu) begin
      c = '0; c.alu_src_a = 1'b1; c.aluout_write = 1'b1;
      c.alu_op = (f == 6'h20) ? 3'b001 : (f == 6'h22) ? 3'b010 : 3'b011;
      exp_q.push_back(c);
      if (exc && oo && addsub) push_exc(w, 1'b1);
      else begin c = '0; c.reg_write = 1'b1; c.reg_dst = 2'd1; exp_q.push_back(c); end
    end else if (o == 6'h00 && f == 6'h08) begin
      c = '0; c.pc_write = 1'b1; c.pc_src = 3'd4; exp_q.push_back(c);
    end else if (o == 6'h08) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'b001; c.aluout_write = 1'b1;
      exp_q.push_back(c);
      if (exc && oo) push_exc(w, 1'b1);
      else begin c = '0; c.reg_write = 1'b1; exp_q.push_back(c); end
    end else if (o == 6'h23 || o == 6'h2B) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'b001; c.aluout_write = 1'b1;
      exp_q.push_back(c);
      for (int i = 0; i <= w; i++) begin
        c = '0; c.iord = 2'd1;
        if (o == 6'h2B) c.mem_wr = 1'b1;
        else            c.mdr_write = (i == w);
        exp_q.push_back(c);
      end
      if (o == 6'h23) begin
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'd1; exp_q.push_back(c);
      end
    end else if (o == 6'h04 || o == 6'h05) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b010; c.pc_src = 3'd1;
      c.pc_write = (o == 6'h04) ? zz : !zz;
      exp_q.push_back(c);
    end else if (o == 6'h02) begin
      c = '0; c.pc_write = 1'b1; c.pc_src = 3'd2; exp_q.push_back(c);
    end else if (exc) begin
      push_exc(w, 1'b0);
    end
  endtask

  // Assert reset asynchronously, hold n cycles, release and check the $29 init cycle.
  task automatic apply_reset(input int n);
    ctl_t c;
    rst[sel] = 1'b1;
    #1 check_eq("rst_async", got[sel], '0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("rst_hold", got[sel], '0);
      @(posedge clk); #1;
    end
    rst[sel] = 1'b0;
    @(negedge clk);
    c = '0; c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
    check_eq("rst_init", got[sel], c);
    @(posedge clk); #1;
  endtask

  // Run one instruction; abort_at >= 0 asserts reset just after that cycle is checked.
  task automatic run_inst(input logic [5:0] o, input logic [5:0] f, input logic zz,
                          input logic oo, input int abort_at);
    op = o; fn = f; z = zz; ov = oo;
    build_expect(cfg_w[sel], cfg_exc[sel], o, f, zz, oo);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("op%02h_fn%02h_c%0d", o, f, i), got[sel], exp_q[i]);
      if (i == abort_at) begin
        #1 apply_reset(1);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 8))
      0, 8:    return 6'h00;
      1:       return 6'h08;
      2:       return 6'h23;
      3:       return 6'h2B;
      4:       return 6'h04;
      5:       return 6'h05;
      6:       return 6'h02;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 4))
      0:       return 6'h20;
      1:       return 6'h22;
      2:       return 6'h24;
      3:       return 6'h08;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      apply_reset(3);
      run_inst(6'h23, 6'h00, 1'b0, 1'b0, -1);  // lw
      run_inst(6'h04, 6'h00, 1'b1, 1'b0, -1);  // beq taken
      run_inst(6'h04, 6'h00, 1'b0, 1'b0, -1);  // beq not taken
      run_inst(6'h05, 6'h00, 1'b0, 1'b0, -1);  // bne taken
      run_inst(6'h3F, 6'h00, 1'b0, 1'b0, -1);  // invalid opcode
      run_inst(6'h00, 6'h20, 1'b0, 1'b1, -1);  // add with overflow
      run_inst(6'h08, 6'h00, 1'b0, 1'b1, -1);  // addi with overflow
      run_inst(6'h00, 6'h22, 1'b0, 1'b0, -1);  // sub, no overflow
      run_inst(6'h00, 6'h08, 1'b0, 1'b0, -1);  // jr
      // sw aborted by reset during its second write cycle
      run_inst(6'h2B, 6'h00, 1'b0, 1'b0, cfg_w[d] + 3 + ((cfg_w[d] > 0) ? 1 : 0));
      for (int k = 0; k < 60; k++) begin
        run_inst(pick_op(), pick_fn(), 1'($urandom), 1'($urandom), -1);
      end
      rst[d] = 1'b1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle control unit for the MIPS-subset datapath. It is the next generation of the team's multicycle controller.
- Adds configurable memory wait states, optional exception handling (invalid opcode, arithmetic overflow) and a reset stack-pointer init sequence.
- Sits between IR/ALU status and every datapath mux select and register write enable.
- Moore outputs decoded from state plus wait counter. PC_Write in BRANCH is the only Mealy output.

Parameters:
- MEM_WAIT, 1: extra cycles a memory read/write must be held before data is valid (0..2^CNT_W-1).
- CNT_W, 3: width of the wait-state counter.
- EXC_EN, 1: 1 = exceptions handled; 0 = invalid opcode executes as NOP and Overflow is ignored.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- OP_Code  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Z  in  1  ALU zero flag, combinational, same cycle
- Overflow  in  1  ALU overflow flag, combinational, same cycle
- PC_Src  out  3  0 ALU result, 1 ALUOut, 2 jump target, 3 MDR byte (exception vector), 4 A (jr)
- IorD  out  2  0 PC, 1 ALUOut, 2 const 253, 3 const 254
- Reg_Dst  out  2  0 rt, 1 rd, 2 reg 29
- MemToReg  out  2  0 ALUOut, 1 MDR, 2 const 227
- ALU_SrcA  out  1  0 PC, 1 A
- ALU_SrcB  out  2  0 B, 1 const 4, 2 sext imm, 3 sext imm<<2
- ALU_Op  out  3  000 pass A, 001 add, 010 sub, 011 and
- PC_Write, Mem_WR, IR_Write, MDR_Write, Reg_Write, A_Write, B_Write, ALUOut_Write, EPC_Write  out  1 each  enables

Behaviour:
- Reset:
  - While reset = 1: state = RESET, counter = 0, all enables 0, all selects 0.
  - On the first clk after release, RESET drives Reg_Write = 1, Reg_Dst = 2, MemToReg = 2 ($29 <= 227), then goes to FETCH.
  - Reset asserted mid-instruction aborts it immediately; no partial writes follow.
- Any output not listed for a state is 0.
- FETCH:
  - Lasts MEM_WAIT+1 cycles.
  - Every cycle: IorD = 0, ALU_SrcA = 0, ALU_SrcB = 1, ALU_Op = 001.
  - Last cycle only: PC_Write = 1, PC_Src = 0, IR_Write = 1. Then go to DECODE.
- DECODE (1 cycle): A_Write = B_Write = ALUOut_Write = 1, ALU_SrcA = 0, ALU_SrcB = 3, ALU_Op = 001. Dispatch:
  - OP 0x00 with Funct 0x20/0x22/0x24 -> R_EXEC.
  - OP 0x00 with Funct 0x08 -> JR.
  - 0x08 -> ADDI_EXEC.
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 -> JUMP.
  - Anything else -> EXC_EPC (cause 0) if EXC_EN, else FETCH.
- R_EXEC:
  - ALU_SrcA = 1, ALU_SrcB = 0, ALUOut_Write = 1; ALU_Op = 001/010/011 per Funct.
  - If Overflow = 1 and EXC_EN and Funct is add/sub -> EXC_EPC (cause 1); else -> R_WB.
- R_WB: Reg_Write = 1, Reg_Dst = 1, MemToReg = 0 -> FETCH.
- ADDI_EXEC: ALU_SrcA = 1, ALU_SrcB = 2, ALU_Op = 001, ALUOut_Write = 1. Overflow handled as in R_EXEC; otherwise -> ADDI_WB.
- ADDI_WB: Reg_Write = 1, Reg_Dst = 0, MemToReg = 0 -> FETCH.
- MEM_ADDR: ALU_SrcA = 1, ALU_SrcB = 2, ALU_Op = 001, ALUOut_Write = 1 -> LW_READ (0x23) or SW_WRITE (0x2B).
- LW_READ: MEM_WAIT+1 cycles with IorD = 1; MDR_Write = 1 on the last cycle -> LW_WB.
- LW_WB: Reg_Write = 1, Reg_Dst = 0, MemToReg = 1 -> FETCH.
- SW_WRITE: MEM_WAIT+1 cycles with IorD = 1 and Mem_WR = 1 every cycle -> FETCH.
- BRANCH (1 cycle):
  - ALU_SrcA = 1, ALU_SrcB = 0, ALU_Op = 010, PC_Src = 1.
  - PC_Write = Z for 0x04, PC_Write = ~Z for 0x05. This is combinational on Z.
  - -> FETCH.
- JUMP: PC_Write = 1, PC_Src = 2 -> FETCH.
- JR: PC_Write = 1, PC_Src = 4 -> FETCH.
- EXC_EPC: ALU_SrcA = 0, ALU_SrcB = 1, ALU_Op = 010, EPC_Write = 1 (EPC <= PC-4) -> EXC_READ.
- EXC_READ: MEM_WAIT+1 cycles with IorD = 2 (cause 0) or 3 (cause 1); MDR_Write = 1 on the last cycle -> EXC_JUMP.
- EXC_JUMP: PC_Write = 1, PC_Src = 3 -> FETCH.
- Cause register (1 bit) is internal, set on exception entry and cleared by reset only.
- Counter behaviour:
  - Resets to 0 on entry to every multi-cycle state.
  - Exit when counter == MEM_WAIT. With MEM_WAIT = 0 these states last 1 cycle.
- Instruction cycle counts (W = MEM_WAIT):
  - R-type: W+4
  - lw: 2W+5
  - sw: 2W+4
  - beq/bne: W+3
  - j/jr: W+3
  - exception (from DECODE): 2W+5 before next FETCH

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; next cycle Reg_Write = 1, Reg_Dst = 2, MemToReg = 2; FETCH follows.
- MEM_WAIT = 1, OP = 0x23 -> IR_Write pulses once at FETCH cycle 2; MDR_Write at cycle 6; Reg_Write with MemToReg = 1 at cycle 7; FETCH at cycle 8.
- OP = 0x04 with Z = 1 -> PC_Write = 1, PC_Src = 1 in BRANCH; repeat with Z = 0 -> PC_Write stays 0; OP = 0x05 with Z = 0 -> PC_Write = 1.
- EXC_EN = 1, OP = 0x3F -> EPC_Write = 1 with ALU_Op = 010, then IorD = 2 for W+1 cycles, then PC_Write = 1 with PC_Src = 3; no Reg_Write or Mem_WR at any point.
- R-type Funct = 0x20 with Overflow = 1 in R_EXEC -> no R_WB and IorD = 3 in EXC_READ; with EXC_EN = 0 -> Reg_Write = 1 with Reg_Dst = 1 as normal; OP = 0x3F -> straight back to FETCH.
- Reset asserted mid-SW_WRITE with MEM_WAIT = 2 -> Mem_WR drops in the same cycle (async); after release, RESET then FETCH with counter restarted at 0.
